// File: rtl/ddr_init_sequencer.sv
// LPDDR4 power-up / recovery sequencer: PLL, PHY and controller resets,
// configuration start handshake, lock-loss and timeout retries.
module ddr_init_sequencer #(
    parameter int unsigned RST_CYCLES   = 1000,
    parameter int unsigned LOCK_TIMEOUT = 1000000,
    parameter int unsigned CFG_TIMEOUT  = 4000000,
    parameter int unsigned MAX_RETRIES  = 3,
    parameter int unsigned CNT_W        = 24,
    parameter logic        CFG_SEL      = 1'b0
) (
    input  logic       regACLK,
    input  logic       rstn,
    input  logic       restart,
    input  logic       ddr_pll_lock,
    input  logic       cfg_done,
    output logic       ddr_pll_rstn,
    output logic       phy_rstn,
    output logic       ctrl_rstn,
    output logic       cfg_reset,
    output logic       cfg_start,
    output logic       cfg_sel,
    output logic       regARESETn,
    output logic       init_done,
    output logic       init_fail,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt
);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_RST   = 3'd2,
        CFG_RUN   = 3'd3,
        DONE      = 3'd4,
        FAIL      = 3'd5,
        RETRY     = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CFG_LAST  = CNT_W'(CFG_TIMEOUT - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;

    logic lock_meta_q, lock_s_q;
    logic done_meta_q, done_s_q;
    logic lock_s, done_s;

    logic pll_rstn_q, pll_rstn_d;
    logic phy_rstn_q, phy_rstn_d;
    logic ctrl_rstn_q, ctrl_rstn_d;
    logic cfg_reset_q, cfg_reset_d;
    logic cfg_start_q, cfg_start_d;
    logic aresetn_q, aresetn_d;
    logic done_q, done_d;
    logic fail_q, fail_d;

    logic timed;

    always_ff @(posedge regACLK or negedge rstn) begin
        if (!rstn) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= ddr_pll_lock;
            lock_s_q    <= lock_meta_q;
            done_meta_q <= cfg_done;
            done_s_q    <= done_meta_q;
        end
    end

    assign lock_s = lock_s_q;
    assign done_s = done_s_q;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            PLL_RST: begin
                if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                // a lock arriving on the timeout cycle still counts
                if (lock_s)                  state_d = REL_RST;
                else if (cnt_q == LOCK_LAST) state_d = RETRY;
            end
            REL_RST: begin
                if (!lock_s)                state_d = RETRY;
                else if (cnt_q == RST_LAST) state_d = CFG_RUN;
            end
            CFG_RUN: begin
                if (!lock_s)                state_d = RETRY;
                else if (done_s)            state_d = DONE;
                else if (cnt_q == CFG_LAST) state_d = RETRY;
            end
            DONE: begin
                if (!lock_s) begin
                    state_d = PLL_RST;
                    retry_d = '0;
                end
            end
            RETRY: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = FAIL;
                end else begin
                    state_d = PLL_RST;
                    retry_d = retry_q + 2'd1;
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLL_RST;
            end
        endcase
        if (restart) begin
            state_d = PLL_RST;
            retry_d = '0;
        end
    end

    assign timed = (state_q == PLL_RST) || (state_q == WAIT_LOCK) ||
                   (state_q == REL_RST) || (state_q == CFG_RUN);

    always_comb begin
        cnt_d = cnt_q;
        if (restart || (state_d != state_q)) cnt_d = '0;
        else if (timed)                      cnt_d = cnt_q + 1'b1;
    end

    // Outputs decoded from the next state so they move with the state edge
    always_comb begin
        pll_rstn_d  = 1'b0;
        phy_rstn_d  = 1'b0;
        ctrl_rstn_d = 1'b0;
        cfg_reset_d = 1'b1;
        cfg_start_d = 1'b0;
        aresetn_d   = 1'b0;
        done_d      = 1'b0;
        fail_d      = 1'b0;
        unique case (state_d)
            WAIT_LOCK: begin
                pll_rstn_d = 1'b1;
            end
            REL_RST: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
            end
            CFG_RUN: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
                cfg_reset_d = 1'b0;
                cfg_start_d = 1'b1;
            end
            DONE: begin
                pll_rstn_d  = 1'b1;
                phy_rstn_d  = 1'b1;
                ctrl_rstn_d = 1'b1;
                cfg_reset_d = 1'b0;
                aresetn_d   = 1'b1;
                done_d      = 1'b1;
            end
            FAIL: begin
                fail_d = 1'b1;
            end
            default: begin
                fail_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge regACLK or negedge rstn) begin
        if (!rstn) begin
            state_q     <= PLL_RST;
            cnt_q       <= '0;
            retry_q     <= '0;
            pll_rstn_q  <= 1'b0;
            phy_rstn_q  <= 1'b0;
            ctrl_rstn_q <= 1'b0;
            cfg_reset_q <= 1'b1;
            cfg_start_q <= 1'b0;
            aresetn_q   <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            pll_rstn_q  <= pll_rstn_d;
            phy_rstn_q  <= phy_rstn_d;
            ctrl_rstn_q <= ctrl_rstn_d;
            cfg_reset_q <= cfg_reset_d;
            cfg_start_q <= cfg_start_d;
            aresetn_q   <= aresetn_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
        end
    end

    assign ddr_pll_rstn = pll_rstn_q;
    assign phy_rstn     = phy_rstn_q;
    assign ctrl_rstn    = ctrl_rstn_q;
    assign cfg_reset    = cfg_reset_q;
    assign cfg_start    = cfg_start_q;
    assign cfg_sel      = CFG_SEL;
    assign regARESETn   = aresetn_q;
    assign init_done    = done_q;
    assign init_fail    = fail_q;
    assign state_o      = state_q;
    assign retry_cnt    = retry_q;

endmodule
